// File: rtl/color_scan_pkg.sv
// Shared encodings for the colour scan engine: sensor filter selects,
// colour codes and the scan FSM state enum.
package color_scan_pkg;

  // Sensor {S3,S2} filter select values
  typedef enum logic [1:0] {
    FILTER_RED   = 2'b00,
    FILTER_BLUE  = 2'b10,
    FILTER_GREEN = 2'b11
  } filter_t;

  // Colour codes written into the packed RAM words
  localparam logic [1:0] COLOR_RED    = 2'b00;
  localparam logic [1:0] COLOR_GREEN  = 2'b01;
  localparam logic [1:0] COLOR_BLUE   = 2'b10;
  localparam logic [1:0] COLOR_YELLOW = 2'b11;

  // Scan sequencer states (also exported on dbg_state)
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ARM     = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DECIDE  = 3'd4,
    ST_PACK    = 3'd5,
    ST_NEXT    = 3'd6,
    ST_FLUSH   = 3'd7
  } state_t;

endpackage

// File: rtl/color_scan_engine_sync_edge_detect.sv
// Two-flop synchroniser for the asynchronous sensor pin followed by a
// registered rising-edge pulse. The pulse lags the pin by three cycles.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  // Synchronise the pin and register a one-cycle pulse on each 0->1 change
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/color_scan_engine.sv
// Colour scan engine: steps through NUM_SENSORS colour sensors, measures the
// sensor output period under the red, green and blue filters, classifies each
// nib as R/G/B/Y and packs the 2-bit colours into RAM words with write strobes.
// Optional build macro COLOR_SCAN_RAW_EN adds raw_r/raw_g/raw_b/raw_valid.
//
// Handshake: start is a one-cycle request accepted only in IDLE (busy=0);
// busy rises the next cycle and falls together with the one-cycle done pulse.
// color_valid and wr_en are one-cycle strobes with no back-pressure; their
// companion buses (color/color_idx, wr_addr/wr_data) are valid in that cycle.
module color_scan_engine
  import color_scan_pkg::*;
#(
  parameter  int NUM_SENSORS   = 12,
  parameter  int CNT_W         = 16,
  parameter  int AVG_LOG2      = 0,
  parameter  int SETTLE_CYC    = 16,
  parameter  int TIMEOUT       = 4095,
  parameter  int NIBS_PER_WORD = 6,
  parameter  int ADDR_W        = 8,
  localparam int SEL_W         = $clog2(NUM_SENSORS),
  localparam int DATA_W        = 2 * NIBS_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              addr_clr,
  input  logic              sensor_in,
  output logic [SEL_W-1:0]  sensor_sel,
  output logic [1:0]        filter_sel,
  output logic              busy,
  output logic              done,
  output logic              color_valid,
  output logic [1:0]        color,
  output logic [SEL_W-1:0]  color_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              timeout_err,
  output logic [2:0]        dbg_state
`ifdef COLOR_SCAN_RAW_EN
  ,
  output logic [CNT_W-1:0]  raw_r,
  output logic [CNT_W-1:0]  raw_g,
  output logic [CNT_W-1:0]  raw_b,
  output logic              raw_valid
`endif
);

  localparam int SET_W     = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W     = $clog2(TIMEOUT + 1);
  localparam int EDGE_W    = AVG_LOG2 + 1;
  localparam int NUM_EDGES = 1 << AVG_LOG2;
  localparam int NIB_W     = $clog2(NIBS_PER_WORD + 1);

  state_t              state_q;
  filter_t             filter_sel_q;
  logic [SEL_W-1:0]    sensor_sel_q;
  logic [SET_W-1:0]    settle_cnt_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic [EDGE_W-1:0]   edge_cnt_q;
  logic [CNT_W-1:0]    acc_q, r_cnt_q, g_cnt_q, b_cnt_q;
  logic [DATA_W-1:0]   pack_q, wr_data_q;
  logic [NIB_W-1:0]    nib_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [SEL_W-1:0]    color_idx_q;
  logic [1:0]          color_q;
  logic                busy_q, done_q, color_valid_q, wr_en_q, timeout_err_q;
`ifdef COLOR_SCAN_RAW_EN
  logic [CNT_W-1:0]    raw_r_q, raw_g_q, raw_b_q;
  logic                raw_valid_q;
`endif

  logic                rise;
  logic [CNT_W-1:0]    acc_inc_d, meas_val_d;
  logic                meas_done_d, meas_tmo_d;
  logic [1:0]          color_d;
  logic [DATA_W-1:0]   flush_data_d;

  sync_edge_detect u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (sensor_in),
    .rise_o  (rise)
  );

  // Blue dominating both others reads as yellow; otherwise strict minimum wins, ties fall to red
  function automatic logic [1:0] classify(input logic [CNT_W-1:0] r,
                                          input logic [CNT_W-1:0] g,
                                          input logic [CNT_W-1:0] b);
    if (b > r && b > g)      return COLOR_YELLOW;
    else if (r < g && r < b) return COLOR_RED;
    else if (g < r && g < b) return COLOR_GREEN;
    else if (b < r && b < g) return COLOR_BLUE;
    else                     return COLOR_RED;
  endfunction

  // Measurement completion: last averaging edge seen, or the edge wait timed out
  always_comb begin
    acc_inc_d    = (&acc_q) ? acc_q : acc_q + 1'b1;
    meas_done_d  = 1'b0;
    meas_tmo_d   = 1'b0;
    meas_val_d   = acc_inc_d;
    color_d      = classify(r_cnt_q, g_cnt_q, b_cnt_q);
    flush_data_d = pack_q << (2 * (NIBS_PER_WORD - int'(nib_q)));
    if (state_q == ST_ARM || state_q == ST_MEASURE) begin
      if (state_q == ST_MEASURE && rise && edge_cnt_q == EDGE_W'(NUM_EDGES - 1)) begin
        meas_done_d = 1'b1;
      end else if (!rise && tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
        meas_done_d = 1'b1;
        meas_tmo_d  = 1'b1;
        meas_val_d  = '1;
      end
    end
  end

  // Scan sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      filter_sel_q  <= FILTER_RED;
      sensor_sel_q  <= '0;
      settle_cnt_q  <= '0;
      tmo_cnt_q     <= '0;
      edge_cnt_q    <= '0;
      acc_q         <= '0;
      r_cnt_q       <= '0;
      g_cnt_q       <= '0;
      b_cnt_q       <= '0;
      pack_q        <= '0;
      wr_data_q     <= '0;
      nib_q         <= '0;
      wr_addr_q     <= '0;
      color_idx_q   <= '0;
      color_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      color_valid_q <= 1'b0;
      wr_en_q       <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef COLOR_SCAN_RAW_EN
      raw_r_q       <= '0;
      raw_g_q       <= '0;
      raw_b_q       <= '0;
      raw_valid_q   <= 1'b0;
`endif
    end else begin
      done_q        <= 1'b0;
      color_valid_q <= 1'b0;
      wr_en_q       <= 1'b0;
`ifdef COLOR_SCAN_RAW_EN
      raw_valid_q   <= 1'b0;
`endif
      // Address post-increments in the cycle the write strobe is visible
      if (wr_en_q) wr_addr_q <= wr_addr_q + 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (addr_clr) wr_addr_q <= '0;
          if (start) begin
            sensor_sel_q  <= '0;
            filter_sel_q  <= FILTER_RED;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            settle_cnt_q  <= '0;
            state_q       <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
            tmo_cnt_q <= '0;
            state_q   <= ST_ARM;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        ST_ARM: begin
          if (rise) begin
            acc_q      <= '0;
            edge_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            state_q    <= ST_MEASURE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        ST_MEASURE: begin
          acc_q <= acc_inc_d;
          if (rise) begin
            tmo_cnt_q  <= '0;
            edge_cnt_q <= edge_cnt_q + 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        ST_DECIDE: begin
          color_q       <= color_d;
          color_idx_q   <= sensor_sel_q;
          color_valid_q <= 1'b1;
          pack_q        <= {pack_q[DATA_W-3:0], color_d};
          nib_q         <= nib_q + 1'b1;
`ifdef COLOR_SCAN_RAW_EN
          raw_r_q       <= r_cnt_q;
          raw_g_q       <= g_cnt_q;
          raw_b_q       <= b_cnt_q;
          raw_valid_q   <= 1'b1;
`endif
          state_q <= (nib_q + 1'b1 == NIB_W'(NIBS_PER_WORD)) ? ST_PACK : ST_NEXT;
        end
        ST_PACK: begin
          wr_en_q   <= 1'b1;
          wr_data_q <= pack_q;
          nib_q     <= '0;
          state_q   <= ST_NEXT;
        end
        ST_NEXT: begin
          if (sensor_sel_q != SEL_W'(NUM_SENSORS - 1)) begin
            sensor_sel_q <= sensor_sel_q + 1'b1;
            filter_sel_q <= FILTER_RED;
            settle_cnt_q <= '0;
            state_q      <= ST_SETTLE;
          end else begin
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (nib_q != '0) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= flush_data_d;
            nib_q     <= '0;
          end else begin
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            sensor_sel_q <= '0;
            filter_sel_q <= FILTER_RED;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A finished measurement latches its count and moves to the next filter
      if (meas_done_d) begin
        case (filter_sel_q)
          FILTER_RED:   r_cnt_q <= meas_val_d;
          FILTER_GREEN: g_cnt_q <= meas_val_d;
          default:      b_cnt_q <= meas_val_d;
        endcase
        if (meas_tmo_d) timeout_err_q <= 1'b1;
        settle_cnt_q <= '0;
        case (filter_sel_q)
          FILTER_RED:   begin filter_sel_q <= FILTER_GREEN; state_q <= ST_SETTLE; end
          FILTER_GREEN: begin filter_sel_q <= FILTER_BLUE;  state_q <= ST_SETTLE; end
          default:      state_q <= ST_DECIDE;
        endcase
      end
    end
  end

  assign sensor_sel  = sensor_sel_q;
  assign filter_sel  = filter_sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign color_valid = color_valid_q;
  assign color       = color_q;
  assign color_idx   = color_idx_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign timeout_err = timeout_err_q;
  assign dbg_state   = state_q;
`ifdef COLOR_SCAN_RAW_EN
  assign raw_r       = raw_r_q;
  assign raw_g       = raw_g_q;
  assign raw_b       = raw_b_q;
  assign raw_valid   = raw_valid_q;
`endif

endmodule

// File: tb/tb_color_scan_engine.sv
// Bench for color_scan_engine: a 12-sensor instance driven by table-driven
// pass vectors, plus a 7-sensor, 1-bit-address instance for the partial-word
// flush and address wrap.
module tb_color_scan_engine;
  import color_scan_pkg::*;

  localparam int NS  = 12;
  localparam int NS2 = 7;

  logic        clk;
  logic        reset;
  logic        start, addr_clr, sensor_in;
  logic [3:0]  sensor_sel, color_idx;
  logic [1:0]  filter_sel, color;
  logic        busy, done, color_valid, wr_en, timeout_err;
  logic [7:0]  wr_addr;
  logic [11:0] wr_data;
  logic [2:0]  dbg_state;

  logic        start2, addr_clr2, sensor_in2;
  logic [2:0]  sensor_sel2, color_idx2;
  logic [1:0]  filter_sel2, color2;
  logic        busy2, done2, color_valid2, wr_en2, timeout_err2;
  logic [0:0]  wr_addr2;
  logic [11:0] wr_data2;
  logic [2:0]  dbg_state2;
`ifdef COLOR_SCAN_RAW_EN
  logic [15:0] raw_r, raw_g, raw_b, raw_r2, raw_g2, raw_b2;
  logic        raw_valid, raw_valid2;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pat1 = 0;
  int pat2 = 0;
  int done_seen = 0;
  int mon_cyc = 0;
  int last_cv_cyc = 0;

  logic [5:0]  exp_q[$];    // {color_idx, color}
  logic [19:0] wexp_q[$];   // {wr_addr, wr_data}

  typedef struct {
    int          pat;
    logic        clr;
    logic [7:0]  addr0;
    logic [11:0] d0;
    logic [11:0] d1;
    logic [7:0]  final_addr;
    logic        tmo;
  } vec_t;
  vec_t vecs[4];

  color_scan_engine #(.TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .start(start), .addr_clr(addr_clr),
    .sensor_in(sensor_in), .sensor_sel(sensor_sel), .filter_sel(filter_sel),
    .busy(busy), .done(done), .color_valid(color_valid), .color(color),
    .color_idx(color_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
`ifdef COLOR_SCAN_RAW_EN
    , .raw_r(raw_r), .raw_g(raw_g), .raw_b(raw_b), .raw_valid(raw_valid)
`endif
  );

  color_scan_engine #(.NUM_SENSORS(NS2), .SETTLE_CYC(4), .TIMEOUT(300), .ADDR_W(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .addr_clr(addr_clr2),
    .sensor_in(sensor_in2), .sensor_sel(sensor_sel2), .filter_sel(filter_sel2),
    .busy(busy2), .done(done2), .color_valid(color_valid2), .color(color2),
    .color_idx(color_idx2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .timeout_err(timeout_err2), .dbg_state(dbg_state2)
`ifdef COLOR_SCAN_RAW_EN
    , .raw_r(raw_r2), .raw_g(raw_g2), .raw_b(raw_b2), .raw_valid(raw_valid2)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sensor period in cycles for a pattern; 0 means the pin is held low.
  // Pattern 0: all red, 1: all yellow, 2: colour = index mod 4, 3: red with sensor 3 dead.
  function automatic int period_of(int pat, int s, logic [1:0] f);
    int r, g, b, cls;
    if (pat == 3 && s == 3) return 0;
    cls = (pat == 1) ? 3 : (pat == 2) ? (s % 4) : 0;
    case (cls)
      0:       begin r = 40; g = 80; b = 80; end
      1:       begin r = 80; g = 40; b = 80; end
      2:       begin r = 80; g = 80; b = 40; end
      default: begin r = 60; g = 60; b = 90; end
    endcase
    case (f)
      2'b11:   return g;
      2'b10:   return b;
      default: return r;
    endcase
  endfunction

  // Reference classifier: counts track the period, a dead pin saturates all three
  function automatic logic [1:0] exp_color(int pat, int s);
    int r, g, b;
    r = period_of(pat, s, 2'b00);
    g = period_of(pat, s, 2'b11);
    b = period_of(pat, s, 2'b10);
    if (r == 0) begin r = 65535; g = 65535; b = 65535; end
    if (b > r && b > g)      return 2'b11;
    else if (r < g && r < b) return 2'b00;
    else if (g < r && g < b) return 2'b01;
    else if (b < r && b < g) return 2'b10;
    else                     return 2'b00;
  endfunction

  // ---------------- sensor drivers ----------------
  initial begin
    int cnt, p;
    cnt = 0;
    sensor_in = 1'b0;
    forever begin
      @(negedge clk);
      p = period_of(pat1, int'(sensor_sel), filter_sel);
      if (p == 0) begin
        sensor_in = 1'b0;
        cnt = 0;
      end else begin
        cnt = (cnt >= p - 1) ? 0 : cnt + 1;
        sensor_in = (cnt < p / 2);
      end
    end
  end

  initial begin
    int cnt, p;
    cnt = 0;
    sensor_in2 = 1'b0;
    forever begin
      @(negedge clk);
      p = period_of(pat2, int'(sensor_sel2), filter_sel2);
      if (p == 0) begin
        sensor_in2 = 1'b0;
        cnt = 0;
      end else begin
        cnt = (cnt >= p - 1) ? 0 : cnt + 1;
        sensor_in2 = (cnt < p / 2);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard for the 12-sensor instance: colour strobes, writes, done pulses
  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (reset && color_valid) begin
        last_cv_cyc = mon_cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_color: idx %0d color %0d with nothing expected", color_idx, color);
        end else begin
          check("color_event", {26'd0, color_idx, color}, {26'd0, exp_q.pop_front()});
        end
      end
      if (reset && wr_en) begin
        check("wr_en_latency", mon_cyc - last_cv_cyc, 1);
        if (wexp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", wr_addr, wr_data);
        end else begin
          check("write", {12'd0, wr_addr, wr_data}, {12'd0, wexp_q.pop_front()});
        end
      end
      if (reset && done) done_seen++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full pass of the 12-sensor instance against a vector record
  task automatic run_vec(input vec_t v, input string nm);
    int cyc;
    pat1 = v.pat;
    for (int s = 0; s < NS; s++) exp_q.push_back({4'(s), exp_color(v.pat, s)});
    wexp_q.push_back({v.addr0, v.d0});
    wexp_q.push_back({v.addr0 + 8'd1, v.d1});
    @(negedge clk);
    start = 1'b1;
    addr_clr = v.clr;
    @(negedge clk);
    start = 1'b0;
    addr_clr = 1'b0;
    check({nm, "_busy_after_start"}, {31'd0, busy}, 1);
    check({nm, "_tmo_cleared_on_start"}, {31'd0, timeout_err}, 0);
    // start and addr_clr while busy must both be ignored
    wait_cycles(300);
    start = 1'b1;
    addr_clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    addr_clr = 1'b0;
    cyc = 0;
    while (!done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_done"}, {31'd0, done}, 1);
    check({nm, "_busy_low_at_done"}, {31'd0, busy}, 0);
    check({nm, "_final_addr"}, {24'd0, wr_addr}, {24'd0, v.final_addr});
    check({nm, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, v.tmo});
    check({nm, "_sensor_sel_home"}, {28'd0, sensor_sel}, 0);
    check({nm, "_colors_pending"}, exp_q.size(), 0);
    check({nm, "_writes_pending"}, wexp_q.size(), 0);
    wait_cycles(5);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, nwr, ncol, d_before;
    logic [11:0] exp_w2 [2];
    reset = 1'b0;
    start = 1'b0;
    addr_clr = 1'b0;
    start2 = 1'b0;
    addr_clr2 = 1'b0;

    vecs[0] = '{pat: 0, clr: 1'b0, addr0: 8'd0, d0: 12'h000, d1: 12'h000, final_addr: 8'd2, tmo: 1'b0};
    vecs[1] = '{pat: 1, clr: 1'b1, addr0: 8'd0, d0: 12'hFFF, d1: 12'hFFF, final_addr: 8'd2, tmo: 1'b0};
    vecs[2] = '{pat: 3, clr: 1'b0, addr0: 8'd2, d0: 12'h000, d1: 12'h000, final_addr: 8'd4, tmo: 1'b1};
    vecs[3] = '{pat: 2, clr: 1'b0, addr0: 8'd4, d0: 12'h1B1, d1: 12'hB1B, final_addr: 8'd6, tmo: 1'b0};

    // Reset state of both instances
    wait_cycles(3);
    check("reset_ctrl", {12'd0, sensor_sel, filter_sel, busy, done, color_valid, color,
                         color_idx, wr_en, timeout_err, dbg_state}, 0);
    check("reset_data", {12'd0, wr_addr, wr_data}, 0);
    check("reset2_ctrl", {14'd0, sensor_sel2, filter_sel2, busy2, done2, color_valid2, color2,
                          color_idx2, wr_en2, timeout_err2, wr_addr2, dbg_state2, wr_data2}, 0);
    reset = 1'b1;
    wait_cycles(2);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of sensor 5's red measurement
    pat1 = 0;
    for (int s = 0; s < 5; s++) exp_q.push_back({4'(s), exp_color(0, s)});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(sensor_sel == 4'd5 && dbg_state == 3'(ST_MEASURE)) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_s5_measure", {25'd0, sensor_sel, dbg_state}, {25'd0, 4'd5, 3'(ST_MEASURE)});
    d_before = done_seen;
    reset = 1'b0;
    @(negedge clk);
    check("midpass_reset_ctrl", {12'd0, sensor_sel, filter_sel, busy, done, color_valid, color,
                                 color_idx, wr_en, timeout_err, dbg_state}, 0);
    check("midpass_reset_data", {12'd0, wr_addr, wr_data}, 0);
    reset = 1'b1;
    wait_cycles(200);
    check("midpass_no_done", done_seen - d_before, 0);
    check("midpass_colors_pending", exp_q.size(), 0);
    check("midpass_still_idle", {31'd0, busy}, 0);
    run_vec(vecs[0], "after_reset");

    // 7-sensor instance: one full word, then a left-aligned partial word, address wraps
    pat2 = 2;
    exp_w2[0] = 12'h1B1;
    exp_w2[1] = 12'h800;
    nwr = 0;
    ncol = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (color_valid2) begin
        check($sformatf("n7_color_s%0d", ncol), {28'd0, color_idx2, color2},
              {28'd0, 3'(ncol), exp_color(2, ncol)});
        ncol++;
      end
      if (wr_en2) begin
        if (nwr < 2) begin
          check($sformatf("n7_write%0d", nwr), {19'd0, wr_addr2, wr_data2},
                {19'd0, 1'(nwr), exp_w2[nwr]});
        end
        nwr++;
      end
    end
    check("n7_done", {31'd0, done2}, 1);
    check("n7_color_count", ncol, NS2);
    check("n7_write_count", nwr, 2);
    check("n7_final_addr_wrapped", {31'd0, wr_addr2}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/color_scan_engine.md
Name: color_scan_engine

Overview:
Parametrised sensor-bar scanner that sequences NUM_SENSORS colour sensors, measures the output period under each of the red/green/blue filters, and classifies each nib as red, green, blue or yellow (RGBY). It packs the 2-bit colours into RAM-width words and issues write strobes, so the cartridge RAM is filled in a single pass. It sits between the sensor-bar pins and the program RAM, and replaces the separate selector and detector handshake pair.

Parameters:
NUM_SENSORS, 12, sensors scanned per pass; SEL_W = $clog2(NUM_SENSORS).
CNT_W, 16, period accumulator width; the accumulator saturates at all-ones.
AVG_LOG2, 0, number of periods accumulated per filter = 2^AVG_LOG2.
SETTLE_CYC, 16, wait in cycles after any change to sensor_sel or filter_sel.
TIMEOUT, 4095, maximum cycles spent waiting for any single edge.
NIBS_PER_WORD, 6, colours per RAM word; DATA_W = 2*NIBS_PER_WORD.
ADDR_W, 8, RAM address width.

Ports:
clk  in  1  system clock (1 MHz domain)
reset  in  1  synchronous, active-low reset
start  in  1  pulse that starts a pass; ignored while busy
addr_clr  in  1  sets wr_addr to 0; honoured only when idle
sensor_in  in  1  asynchronous sensor frequency output
sensor_sel  out  SEL_W  index of the active sensor
filter_sel  out  2  sensor {S3,S2} filter select: RED=00, GREEN=11, BLUE=10
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at the end of a pass
color_valid  out  1  one-cycle pulse; color and color_idx are valid in the same cycle
color  out  2  00=red, 01=green, 10=blue, 11=yellow
color_idx  out  SEL_W  index of the sensor that produced color
wr_en  out  1  one-cycle RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  DATA_W  packed colours; the first nib is in the MSBs
timeout_err  out  1  sticky flag, cleared when the next start is accepted

Behaviour:
- Reset (reset=0 at a clk edge): the FSM goes to IDLE. All outputs become 0 (filter_sel=00). The accumulator, packing register, nib count and wr_addr are cleared. Reset mid-pass aborts the pass; no partial write and no done pulse are issued.
- sensor_in passes through a 2-flop synchroniser plus a rising-edge detector. The edge pulse therefore lags the pin by 3 cycles.
- FSM states:
  - IDLE: waits for start. Accepting start sets sensor_sel=0, filter_sel=RED, clears timeout_err, and moves to SETTLE.
  - SETTLE: counts SETTLE_CYC cycles, then moves to ARM.
  - ARM: waits for the first edge; on that edge the accumulator is cleared and the FSM moves to MEASURE.
  - MEASURE: the accumulator increments every cycle (saturating). It stays in MEASURE until 2^AVG_LOG2 further edges have been seen, then latches the result into r_cnt, g_cnt or b_cnt.
  - Filter order is RED → GREEN → BLUE; after each filter change the FSM returns to SETTLE. After BLUE it moves to DECIDE.
  - DECIDE: applies the decision rules below and pulses color_valid for one cycle. It shifts the colour into the pack register (pack = pack<<2 | color) and increments the nib count.
  - PACK: taken if nib count == NIBS_PER_WORD. It pulses wr_en with the current wr_addr, post-increments wr_addr (wraps modulo 2^ADDR_W), and clears the nib count.
  - NEXT: if sensor_sel != NUM_SENSORS-1, increments sensor_sel, sets filter_sel=RED and returns to SETTLE. Otherwise it moves to FLUSH.
  - FLUSH: if the nib count is nonzero, left-aligns the partial word (zero-padded LSBs) and writes it as in PACK. Then pulses done, drops busy, and returns to IDLE. sensor_sel returns to 0.
- Timeout: in ARM or MEASURE, if TIMEOUT cycles pass without an edge, the current filter's count is forced to all-ones and timeout_err is set. The scan then continues with the next filter as normal.
- Decision rules, applied in order:
  1. b_cnt > r_cnt and b_cnt > g_cnt → yellow (11).
  2. Else r_cnt strictly smallest → 00.
  3. Else g_cnt strictly smallest → 01.
  4. Else b_cnt strictly smallest → 10.
  5. Else (tie) → 00.
- Latency: wr_en occurs exactly 1 cycle after the color_valid that completes a word.
- Simultaneous events: start while busy is ignored. addr_clr while busy is ignored. addr_clr and start together when idle: the address is cleared, then the pass starts.
- Consecutive passes continue from the current wr_addr.

Optional Feature:
COLOR_SCAN_RAW_EN:
- Defined: adds output ports raw_r, raw_g and raw_b (each CNT_W wide) plus raw_valid. These hold the latched counts and update in the same cycle as color_valid.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package color_scan_pkg holds:
  - filter encodings FILTER_RED/GREEN/BLUE;
  - colour encodings COLOR_RED/GREEN/BLUE/YELLOW;
  - the FSM state enum.
- One natural sub-module, sync_edge_detect: 2-flop synchroniser plus rising-edge pulse, with synchronous active-low reset.

Test Plan:
- Sensor periods R=40, G=80, B=80 cycles, NUM_SENSORS=12 → 12 color_valid pulses with color=00. wr_en occurs twice, at addr 0 and 1 with wr_data=12'h000, followed by done.
- Periods R=60, G=60, B=90 (yellow) on all sensors → every colour is 11, wr_data=12'hFFF. wr_addr is 2 after the pass.
- Sensor index i gets colour (i mod 4) (R,G,B,Y via period patterns) → wr_data = 12'h1B1 (00 01 10 11 00 01), then 12'hB1B.
- sensor_in held low on sensor 3 → timeout_err=1; that sensor classifies as 00 (all counts saturated, tie) and the pass still completes with done.
- NUM_SENSORS=7, wr_addr preset to 255 → two writes: addr 255, then addr 0 with partial word [nib6,0000000000]. Final wr_addr=1.
- reset asserted mid-MEASURE on sensor 5 → all outputs 0 next cycle, no wr_en, no done. A new start gives a normal full pass from sensor 0.
